// File: rtl/frame_update_pkg.sv
// frame_update_pkg: 800x600 VGA timing constants, parameter defaults and commit FSM states.
package frame_update_pkg;
   localparam int H_TOTAL   = 1056;
   localparam int V_TOTAL   = 628;
   localparam int H_ACTIVE  = 800;
   localparam int V_ACTIVE  = 600;
   localparam int N_REQ_DEF = 4;
   localparam int XW_DEF    = $clog2(H_TOTAL);
   localparam int YW_DEF    = $clog2(V_TOTAL);
   typedef enum logic [1:0] {ACTIVE, COMMIT, BLANK} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wraparound.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             vld
);
   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int k = 1; k <= N_REQ; k++)
         if (!vld && req[(int'(ptr) + k) % N_REQ]) begin
            vld = 1'b1;
            idx = IW'((int'(ptr) + k) % N_REQ);
            gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
         end
   end
endmodule

// File: rtl/frame_update_arbiter.sv
// frame_update_arbiter: round-robin position posts into pending regs, committed together at the vblnk rise.
// Define FRAME_UPDATE_OVERWRITE_CNT_EN to add the saturating overwrite_cnt output.
module frame_update_arbiter
   import frame_update_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int XW    = XW_DEF,
   parameter int YW    = YW_DEF
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               vblnk,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*XW-1:0] xpos_in,
   input  logic [N_REQ*YW-1:0] ypos_in,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ*XW-1:0] xpos_out,
   output logic [N_REQ*YW-1:0] ypos_out,
   output logic               frame_tick,
`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
   output logic [7:0]         overwrite_cnt,
`endif
   output logic [N_REQ-1:0]   dirty
);
   localparam int IW = $clog2(N_REQ);
   state_e state_q, state_d;
   logic vblnk_q, armed_q, commit, frame_tick_q, frame_tick_d, gnt_vld;
   logic [N_REQ-1:0] ack_q, dirty_q, dirty_d, eligible, gnt;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
   logic [N_REQ*XW-1:0] pend_x_q, pend_x_d, out_x_q, out_x_d;
   logic [N_REQ*YW-1:0] pend_y_q, pend_y_d, out_y_q, out_y_d;

   // armed_q stops a vblnk already high at reset release from reading as a rising edge
   assign commit   = vblnk & ~vblnk_q & armed_q;
   assign eligible = req & ~ack_q & ~{N_REQ{commit}};

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req(eligible),
      .ptr(rr_ptr_q),
      .gnt(gnt),
      .idx(gnt_idx),
      .vld(gnt_vld)
   );

   always_comb begin
      state_d = (state_q == COMMIT) ? BLANK :
                (state_q == BLANK)  ? (vblnk ? BLANK : ACTIVE) :
                (commit ? COMMIT : ACTIVE);
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      out_x_d = out_x_q;
      out_y_d = out_y_q;
      dirty_d = dirty_q;
      rr_ptr_d = rr_ptr_q;
      frame_tick_d = commit & |dirty_q;
      if (gnt_vld) begin
         pend_x_d[int'(gnt_idx)*XW +: XW] = xpos_in[int'(gnt_idx)*XW +: XW];
         pend_y_d[int'(gnt_idx)*YW +: YW] = ypos_in[int'(gnt_idx)*YW +: YW];
         dirty_d[gnt_idx] = 1'b1;
         rr_ptr_d = gnt_idx;
      end
      for (int i = 0; i < N_REQ; i++)
         if (commit && dirty_q[i]) begin
            out_x_d[i*XW +: XW] = pend_x_q[i*XW +: XW];
            out_y_d[i*YW +: YW] = pend_y_q[i*YW +: YW];
            dirty_d[i] = 1'b0;
         end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= ACTIVE;
         vblnk_q <= 1'b0;
         armed_q <= 1'b0;
         ack_q <= '0;
         dirty_q <= '0;
         rr_ptr_q <= IW'(N_REQ - 1);
         frame_tick_q <= 1'b0;
         pend_x_q <= '0;
         pend_y_q <= '0;
         out_x_q <= '0;
         out_y_q <= '0;
      end else begin
         state_q <= state_d;
         vblnk_q <= vblnk;
         armed_q <= 1'b1;
         ack_q <= gnt;
         dirty_q <= dirty_d;
         rr_ptr_q <= rr_ptr_d;
         frame_tick_q <= frame_tick_d;
         pend_x_q <= pend_x_d;
         pend_y_q <= pend_y_d;
         out_x_q <= out_x_d;
         out_y_q <= out_y_d;
      end
   end

`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
   logic [7:0] overwrite_cnt_q, overwrite_cnt_d;
   always_comb
      overwrite_cnt_d = (gnt_vld && dirty_q[gnt_idx] && overwrite_cnt_q != 8'hFF) ? overwrite_cnt_q + 8'd1 : overwrite_cnt_q;
   always_ff @(posedge pclk)
      overwrite_cnt_q <= rst ? 8'd0 : overwrite_cnt_d;
   assign overwrite_cnt = overwrite_cnt_q;
`endif

   assign ack        = ack_q;
   assign dirty      = dirty_q;
   assign frame_tick = frame_tick_q;
   assign xpos_out   = out_x_q;
   assign ypos_out   = out_y_q;
endmodule

// File: tb/tb_frame_update_arbiter.sv
// tb_frame_update_arbiter: directed scenarios plus randomized traffic against a per-requester reference model.
module tb_frame_update_arbiter;
   import frame_update_pkg::*;
   localparam int N = 4, XW = 11, YW = 10;
   logic pclk = 1'b0, rst = 1'b1, vblnk = 1'b0;
   logic [N-1:0] req = '0;
   logic [N*XW-1:0] xpos_in = '0;
   logic [N*YW-1:0] ypos_in = '0;
   logic [N-1:0] ack, dirty;
   logic [N*XW-1:0] xpos_out;
   logic [N*YW-1:0] ypos_out;
   logic frame_tick;
`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
   logic [7:0] overwrite_cnt;
`endif
   int checks = 0, failures = 0;

   // reference model: one record per requester, plus rotation and edge-detect history
   int m_px[N], m_py[N], m_ox[N], m_oy[N];
   bit m_dirty[N], m_ack[N];
   int m_rr, m_ocnt;
   bit m_vq, m_armed, m_tick;

   frame_update_arbiter #(.N_REQ(N), .XW(XW), .YW(YW)) dut (
      .pclk(pclk),
      .rst(rst),
      .vblnk(vblnk),
      .req(req),
      .xpos_in(xpos_in),
      .ypos_in(ypos_in),
      .ack(ack),
      .xpos_out(xpos_out),
      .ypos_out(ypos_out),
      .frame_tick(frame_tick),
`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
      .overwrite_cnt(overwrite_cnt),
`endif
      .dirty(dirty)
   );

   always #5 pclk = ~pclk;

   function automatic void model_step();
      bit commit;
      int g;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_px[i] = 0; m_py[i] = 0; m_ox[i] = 0; m_oy[i] = 0; m_dirty[i] = 0; m_ack[i] = 0;
         end
         m_rr = N - 1; m_ocnt = 0; m_vq = 0; m_armed = 0; m_tick = 0;
         return;
      end
      commit = vblnk && !m_vq && m_armed;
      m_tick = 0;
      g = -1;
      if (commit) begin
         for (int i = 0; i < N; i++)
            if (m_dirty[i]) begin
               m_ox[i] = m_px[i]; m_oy[i] = m_py[i]; m_dirty[i] = 0; m_tick = 1;
            end
      end else
         for (int k = 1; k <= N && g < 0; k++)
            if (req[(m_rr + k) % N] && !m_ack[(m_rr + k) % N]) g = (m_rr + k) % N;
      for (int i = 0; i < N; i++) m_ack[i] = (i == g);
      if (g >= 0) begin
         if (m_dirty[g] && m_ocnt < 255) m_ocnt++;
         m_px[g] = int'(xpos_in[g*XW +: XW]);
         m_py[g] = int'(ypos_in[g*YW +: YW]);
         m_dirty[g] = 1;
         m_rr = g;
      end
      m_vq = vblnk;
      m_armed = 1;
   endfunction

   task automatic tick();
      model_step();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset(input logic vb);
      rst = 1'b1; vblnk = vb; req = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic post(input int i, input int x, input int y);
      int n = 0;
      req[i] = 1'b1;
      xpos_in[i*XW +: XW] = XW'(x);
      ypos_in[i*YW +: YW] = YW'(y);
      do begin tick(); n++; end while (!ack[i] && n < 20);
      checks++;
      if (ack[i] !== 1'b1) begin failures++; $display("FAIL post_ack req=%0d got=%b exp=1", i, ack[i]); end
      req[i] = 1'b0;
   endtask

   task automatic test_reset();
      bit clean = 1;
      rst = 1'b1; vblnk = 1'b0; req = '0;
      tick(); tick();
      checks++;
      if ({ack, dirty, frame_tick, xpos_out, ypos_out} !== '0) begin
         failures++; $display("FAIL reset_values got ack=%b dirty=%b tick=%b x=%h y=%h exp all 0", ack, dirty, frame_tick, xpos_out, ypos_out);
      end
      rst = 1'b0;
      repeat (100) begin
         tick();
         if ({ack, dirty, frame_tick, xpos_out, ypos_out} !== '0) clean = 0;
      end
      checks++;
      if (!clean) begin failures++; $display("FAIL reset_idle got activity while idle exp all outputs 0"); end
   endtask

   task automatic test_single();
      do_reset(1'b0);
      req[1] = 1'b1; xpos_in[XW +: XW] = 11'd400; ypos_in[YW +: YW] = 10'd300;
      tick();
      checks++;
      if (ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", ack); end
      tick();
      checks++;
      if (ack !== 4'b0000) begin failures++; $display("FAIL single_ack_once got=%b exp=0000", ack); end
      req[1] = 1'b0;
      tick();
      checks++;
      if (dirty !== 4'b0010 || xpos_out !== '0 || frame_tick !== 1'b0) begin
         failures++; $display("FAIL single_pending got dirty=%b x=%h exp dirty=0010 x=0", dirty, xpos_out);
      end
      vblnk = 1'b1;
      tick();
      checks++;
      if (xpos_out[XW +: XW] !== 11'd400 || ypos_out[YW +: YW] !== 10'd300 || frame_tick !== 1'b1 || dirty !== '0) begin
         failures++; $display("FAIL single_commit got x=%0d y=%0d tick=%b dirty=%b exp 400 300 1 0000",
                              xpos_out[XW +: XW], ypos_out[YW +: YW], frame_tick, dirty);
      end
      tick();
      checks++;
      if (frame_tick !== 1'b0) begin failures++; $display("FAIL single_tick_once got=%b exp=0", frame_tick); end
      vblnk = 1'b0;
      tick();
   endtask

   task automatic test_rotation();
      do_reset(1'b0);
      for (int r = 0; r < 4; r++) begin
         int got[$];
         int n = 0;
         req = '1;
         while (req != '0 && n < 20) begin
            tick(); n++;
            for (int i = 0; i < N; i++) if (ack[i]) begin got.push_back(i); req[i] = 1'b0; end
         end
         checks++;
         if (n != 4 || got.size() != 4 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3) begin
            failures++; $display("FAIL rotation round=%0d got order=%p cycles=%0d exp order 0,1,2,3 in 4 cycles", r, got, n);
         end
         tick();
      end
   endtask

   task automatic test_overwrite();
      do_reset(1'b0);
      post(2, 10, 1);
      post(2, 20, 2);
      tick();
      vblnk = 1'b1;
      tick();
      checks++;
      if (xpos_out[2*XW +: XW] !== 11'd20 || ypos_out[2*YW +: YW] !== 10'd2) begin
         failures++; $display("FAIL overwrite_last got x=%0d y=%0d exp 20 2", xpos_out[2*XW +: XW], ypos_out[2*YW +: YW]);
      end
`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
      checks++;
      if (overwrite_cnt !== 8'd1) begin failures++; $display("FAIL overwrite_cnt got=%0d exp=1", overwrite_cnt); end
`endif
      vblnk = 1'b0;
      tick();
   endtask

   task automatic test_commit_edge();
      bit held = 1;
      do_reset(1'b0);
      post(3, 111, 11);
      vblnk = 1'b1;
      tick();
      vblnk = 1'b0;
      repeat (3) tick();
      vblnk = 1'b1; req[3] = 1'b1; xpos_in[3*XW +: XW] = 11'd222; ypos_in[3*YW +: YW] = 10'd22;
      tick();
      checks++;
      if (ack !== 4'b0000 || frame_tick !== 1'b0 || xpos_out[3*XW +: XW] !== 11'd111) begin
         failures++; $display("FAIL edge_no_grant got ack=%b tick=%b x=%0d exp 0000 0 111", ack, frame_tick, xpos_out[3*XW +: XW]);
      end
      tick();
      checks++;
      if (ack !== 4'b1000) begin failures++; $display("FAIL edge_late_ack got=%b exp=1000", ack); end
      req[3] = 1'b0;
      // a shortened frame stands in for the full H_TOTAL*V_TOTAL period
      repeat (8) begin tick(); if (xpos_out[3*XW +: XW] !== 11'd111 || dirty !== 4'b1000) held = 0; end
      vblnk = 1'b0;
      repeat (30) begin tick(); if (xpos_out[3*XW +: XW] !== 11'd111 || dirty !== 4'b1000) held = 0; end
      checks++;
      if (!held) begin failures++; $display("FAIL edge_hold got output changed or dirty lost exp x=111 dirty=1000"); end
      vblnk = 1'b1;
      tick();
      checks++;
      if (xpos_out[3*XW +: XW] !== 11'd222 || ypos_out[3*YW +: YW] !== 10'd22 || frame_tick !== 1'b1) begin
         failures++; $display("FAIL edge_next_frame got x=%0d y=%0d tick=%b exp 222 22 1", xpos_out[3*XW +: XW], ypos_out[3*YW +: YW], frame_tick);
      end
      vblnk = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      post(1, 500, 400);
      tick();
      checks++;
      if (dirty !== 4'b0010) begin failures++; $display("FAIL mid_dirty got=%b exp=0010", dirty); end
      req[2] = 1'b1; xpos_in[2*XW +: XW] = 11'd5; rst = 1'b1;
      tick();
      rst = 1'b0; req[2] = 1'b0;
      checks++;
      if (ack !== '0 || dirty !== '0 || xpos_out !== '0 || ypos_out !== '0) begin
         failures++; $display("FAIL mid_reset got ack=%b dirty=%b x=%h exp all 0", ack, dirty, xpos_out);
      end
      tick();
      checks++;
      if (ack !== '0) begin failures++; $display("FAIL mid_no_ack got=%b exp=0000", ack); end
      vblnk = 1'b1;
      tick();
      checks++;
      if (frame_tick !== 1'b0 || xpos_out !== '0 || ypos_out !== '0) begin
         failures++; $display("FAIL mid_no_commit got tick=%b x=%h exp 0 0", frame_tick, xpos_out);
      end
      vblnk = 1'b0;
      tick();
   endtask

   task automatic test_vblnk_at_reset();
      do_reset(1'b1);
      post(0, 77, 7);
      repeat (4) tick();
      checks++;
      if (frame_tick !== 1'b0 || xpos_out !== '0 || dirty !== 4'b0001) begin
         failures++; $display("FAIL blank_at_reset got tick=%b x=%h dirty=%b exp 0 0 0001", frame_tick, xpos_out, dirty);
      end
      vblnk = 1'b0;
      repeat (5) tick();
      vblnk = 1'b1;
      tick();
      checks++;
      if (xpos_out[XW-1:0] !== 11'd77 || ypos_out[YW-1:0] !== 10'd7 || frame_tick !== 1'b1) begin
         failures++; $display("FAIL blank_first_rise got x=%0d y=%0d tick=%b exp 77 7 1", xpos_out[XW-1:0], ypos_out[YW-1:0], frame_tick);
      end
      vblnk = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] e_ack, e_dirty;
      logic [N*XW-1:0] e_x;
      logic [N*YW-1:0] e_y;
      do_reset(1'b0);
      for (int c = 0; c < 2000; c++) begin
         vblnk = (c % 48) >= 38;
         for (int i = 0; i < N; i++)
            if (ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               xpos_in[i*XW +: XW] = XW'($urandom_range(0, H_ACTIVE - 1));
               ypos_in[i*YW +: YW] = YW'($urandom_range(0, V_ACTIVE - 1));
            end
         tick();
         for (int i = 0; i < N; i++) begin
            e_ack[i] = m_ack[i]; e_dirty[i] = m_dirty[i];
            e_x[i*XW +: XW] = XW'(m_ox[i]); e_y[i*YW +: YW] = YW'(m_oy[i]);
         end
         checks++;
         if ({ack, dirty, frame_tick} !== {e_ack, e_dirty, m_tick}) begin
            failures++; $display("FAIL rand_ctrl cyc=%0d got ack=%b dirty=%b tick=%b exp ack=%b dirty=%b tick=%b",
                                 c, ack, dirty, frame_tick, e_ack, e_dirty, m_tick);
         end
         checks++;
         if (xpos_out !== e_x || ypos_out !== e_y) begin
            failures++; $display("FAIL rand_pos cyc=%0d got x=%h y=%h exp x=%h y=%h", c, xpos_out, ypos_out, e_x, e_y);
         end
      end
`ifdef FRAME_UPDATE_OVERWRITE_CNT_EN
      checks++;
      if (overwrite_cnt !== 8'(m_ocnt)) begin failures++; $display("FAIL rand_ocnt got=%0d exp=%0d", overwrite_cnt, m_ocnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_overwrite();
      test_commit_edge();
      test_reset_mid();
      test_vblnk_at_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/frame_update_arbiter.md
# frame_update_arbiter

Tear-free position-update scheduler for the 800x600 VGA drawing pipeline in the pixel-clock domain. Up to N_REQ producers (mouse, game logic, keyboard-driven objects) post new object x/y positions at any time through a req/ack handshake. Posts are arbitrated round-robin into pending registers. All pending positions are committed to the drawing stage together, once per frame, at the rising edge of vertical blanking.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- XW, 11, x position width (covers 1056 total columns)
- YW, 10, y position width (covers 628 total lines)

Ports:
- pclk  in  1  pixel clock, 40 MHz; single clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blanking from the timing generator, high for lines 600..627
- req  in  N_REQ  per-requester update request; held with data until ack
- xpos_in  in  N_REQ*XW  requester i x position at bits [i*XW +: XW]
- ypos_in  in  N_REQ*YW  requester i y position at bits [i*YW +: YW]
- ack  out  N_REQ  one-cycle pulse: data accepted into pending
- xpos_out  out  N_REQ*XW  committed x positions to the drawing stage
- ypos_out  out  N_REQ*YW  committed y positions to the drawing stage
- frame_tick  out  1  one-cycle pulse when committed outputs change
- dirty  out  N_REQ  pending entry holds an uncommitted update

## Operation
- Per-requester state: pending x/y and a dirty bit. A round-robin pointer rr_ptr holds the last granted index.
- Each cycle, the arbiter grants at most one requester from eligible = req & ~ack & ~{N_REQ{commit}}. Search starts at rr_ptr+1 mod N_REQ.
- On grant i: capture xpos_in/ypos_in slice i into pending[i], set dirty[i], set rr_ptr=i, and assert ack[i] in the next cycle.
- A requester drops req in the cycle after ack. Masking by ack prevents double capture.
- commit = vblnk & ~vblnk_q, where vblnk_q is vblnk registered.
- On commit, every entry with dirty set copies pending to xpos_out/ypos_out and clears dirty. Non-dirty outputs hold their value.
- frame_tick is high in the cycle after commit, aligned with the new output values.
- FSM, 2-bit state:
  - ACTIVE: vblnk low; accept updates.
  - COMMIT: single cycle on the vblnk rise; no grants.
  - BLANK: vblnk high; accept updates, which commit next frame.
  - Transitions: BLANK -> ACTIVE on vblnk low; ACTIVE -> COMMIT on commit; COMMIT -> BLANK unconditionally.
- Repost before commit: the later post overwrites pending; last write wins.
- A req that arrives during the COMMIT cycle is granted no earlier than the next cycle and commits next frame.
- If vblnk is already high when reset releases, no commit occurs until the next rising edge.

## Timing
- Uncontended grant: req high in cycle 0, data sampled at the end of cycle 0, ack high in cycle 1.
- With k competing requesters, worst-case wait is N_REQ-1 grants after eligibility.
- Commit latency: vblnk rises in cycle t; outputs update and frame_tick pulses in cycle t+1.
- Reset values:
  - ack = 0, frame_tick = 0, dirty = 0
  - xpos_out = 0, ypos_out = 0, pending = 0
  - rr_ptr = N_REQ-1, so index 0 wins first
  - state = ACTIVE, vblnk_q = 0
- Reset asserted mid-handshake discards pending data; no ack is issued for it.

## Configuration
- FRAME_UPDATE_OVERWRITE_CNT_EN defined:
  - Adds output overwrite_cnt, 8 bits, saturating at 255.
  - Increments when a grant hits an entry whose dirty bit is already set.
  - Cleared on rst only.
- Not defined: port absent, no counter logic.

## Structure
- Package frame_update_pkg holds:
  - Timing constants H_TOTAL=1056, V_TOTAL=628, H_ACTIVE=800, V_ACTIVE=600.
  - Defaults for XW, YW, N_REQ.
  - FSM state enum: ACTIVE, COMMIT, BLANK.
- One sub-module, rr_arbiter, parameterized by N_REQ: request vector plus pointer in, one-hot grant and encoded index out; purely combinational.

## Test plan
- Reset, then hold vblnk=0 for 100 cycles -> all outputs 0, ack never pulses, dirty=0.
- req[1]=1 with x=400, y=300 -> ack[1] high in cycle +1 only, dirty[1]=1, xpos_out unchanged until vblnk rises. After the rise, slice 1 reads 400/300, frame_tick pulses once, dirty[1]=0.
- req[0..3] asserted in the same cycle -> acks in order 0,1,2,3 on consecutive cycles. Then re-assert all three times -> grant order continues the rotation with no starvation.
- req[2] posts x=10, then x=20 before vblnk -> committed x=20. With FRAME_UPDATE_OVERWRITE_CNT_EN, overwrite_cnt=1.
- req[3] asserted in the exact cycle vblnk rises -> no ack that cycle, ack the next cycle. Output keeps its old value this frame and updates at the following vblnk rise, 628*1056 cycles later.
- Assert rst for one cycle while req[1] is pending and dirty -> dirty=0, outputs 0, no commit at the next vblnk.
